// File: rtl/elastic_skid_buffer.sv
// Two-entry ready/valid skid buffer: a main register drives data_o and a skid
// register absorbs the one word in flight when downstream stalls.
module elastic_skid_buffer #(
  parameter int unsigned        width_p     = 8,
  parameter logic [width_p-1:0] reset_val_p = '0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [width_p-1:0] data_o
);

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] BUSY  = 2'b01;
  localparam logic [1:0] FULL  = 2'b10;

  logic [1:0]         state_q, state_d;
  logic [width_p-1:0] main_q, main_d;
  logic [width_p-1:0] skid_q, skid_d;
  logic               in_xfer, out_xfer;

  // Handshake outputs depend only on registered state and reset, never on ready_i.
  assign valid_o  = ~reset_i & (state_q != EMPTY);
  assign ready_o  = ~reset_i & (state_q != FULL);
  assign data_o   = main_q;

  assign in_xfer  = valid_i & ready_o;
  assign out_xfer = valid_o & ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_d  = data_i;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_xfer && out_xfer) begin
          main_d = data_i;
        end else if (in_xfer) begin
          skid_d  = data_i;
          state_d = FULL;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= EMPTY;
      main_q  <= reset_val_p;
      skid_q  <= reset_val_p;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_elastic_skid_buffer.sv
// Scoreboard bench for elastic_skid_buffer: the driver queues accepted words,
// a negedge monitor pops and compares every output transfer.
module tb_elastic_skid_buffer;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_i;
  logic       valid_o;
  logic       ready_drv;
  logic       probe;
  logic       ready_i;
  logic [7:0] data_o;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [7:0]  exp_q[$];

  assign ready_i = ready_drv ^ probe;

  always #5 clk = ~clk;

  elastic_skid_buffer #(
    .width_p    (8),
    .reset_val_p(8'h00)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_i (data_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .data_o (data_o)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Inputs change 1 after posedge; ready_o/valid_o sampled at the following negedge.
  task automatic drive(input logic v, input logic [7:0] d, input logic r,
                       output logic acc, output logic vo, output logic ro);
    valid_i   = v;
    data_i    = d;
    ready_drv = r;
    @(negedge clk);
    ro  = ready_o;
    vo  = valid_o;
    acc = v & ro & ~reset_i;
    @(posedge clk);
    #1;
    if (acc) exp_q.push_back(d);
  endtask

  initial begin : monitor
    logic       r_save, ro0, stall_prev;
    logic [7:0] d_prev, want;
    stall_prev = 1'b0;
    d_prev     = '0;
    probe      = 1'b0;
    forever begin
      @(negedge clk);
      r_save = ready_drv;
      ro0    = ready_o;
      probe  = 1'b1;
      #1;
      check("ready_o_indep_of_ready_i", {31'd0, ready_o}, {31'd0, ro0});
      probe = 1'b0;
      #1;
      if (reset_i) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_valid_hold", {31'd0, valid_o}, 32'd1);
          check("stall_data_hold", {24'd0, data_o}, {24'd0, d_prev});
        end
        if (valid_o && r_save) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", {31'd0, valid_o}, 32'd0);
          end else begin
            want = exp_q.pop_front();
            check("out_data", {24'd0, data_o}, {24'd0, want});
          end
        end
        stall_prev = valid_o & ~r_save;
        d_prev     = data_o;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: actual timeout required finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1);
  end

  initial begin : stim
    logic       acc, vo, ro, hold;
    logic [7:0] hd, d;
    logic       v, r;

    // 1. Reset with valid input present
    reset_i   = 1'b1;
    valid_i   = 1'b1;
    data_i    = 8'hAA;
    ready_drv = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("reset_valid_o", {31'd0, valid_o}, 32'd0);
      check("reset_ready_o", {31'd0, ready_o}, 32'd0);
      @(posedge clk);
    end
    #1;
    reset_i = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    check("post_reset_ready_o", {31'd0, ready_o}, 32'd1);
    check("post_reset_valid_o", {31'd0, valid_o}, 32'd0);
    check("post_reset_data_o", {24'd0, data_o}, 32'h00);
    @(posedge clk);
    #1;

    // 2. Streaming 0x01..0x10
    for (int unsigned i = 1; i <= 16; i++) begin
      drive(1'b1, 8'(i), 1'b1, acc, vo, ro);
      check("stream_ready_o", {31'd0, ro}, 32'd1);
      if (i > 1) check("stream_valid_o", {31'd0, vo}, 32'd1);
    end
    drive(1'b0, 8'h00, 1'b1, acc, vo, ro);
    check("stream_last_valid", {31'd0, vo}, 32'd1);
    drive(1'b0, 8'h00, 1'b1, acc, vo, ro);
    check("stream_drained", exp_q.size(), 32'd0);

    // 3. Stall with back-to-back input
    drive(1'b1, 8'h11, 1'b0, acc, vo, ro);
    check("stall_acc_11", {31'd0, acc}, 32'd1);
    drive(1'b1, 8'h22, 1'b0, acc, vo, ro);
    check("stall_acc_22", {31'd0, acc}, 32'd1);
    drive(1'b1, 8'h33, 1'b0, acc, vo, ro);
    check("stall_full_ready_o", {31'd0, ro}, 32'd0);
    check("stall_main_11", {24'd0, data_o}, 32'h11);
    drive(1'b1, 8'h33, 1'b1, acc, vo, ro);
    check("stall_release_ready_o", {31'd0, ro}, 32'd0);
    drive(1'b1, 8'h33, 1'b1, acc, vo, ro);
    check("stall_acc_33", {31'd0, acc}, 32'd1);
    drive(1'b0, 8'h00, 1'b1, acc, vo, ro);
    drive(1'b0, 8'h00, 1'b1, acc, vo, ro);
    check("stall_drained_valid", {31'd0, vo}, 32'd0);
    check("stall_drained", exp_q.size(), 32'd0);

    // 4. Drain from FULL
    drive(1'b1, 8'h44, 1'b0, acc, vo, ro);
    drive(1'b1, 8'h55, 1'b0, acc, vo, ro);
    drive(1'b0, 8'h00, 1'b1, acc, vo, ro);
    check("drain_full_ready_o", {31'd0, ro}, 32'd0);
    drive(1'b0, 8'h00, 1'b1, acc, vo, ro);
    check("drain_ready_o_after_first", {31'd0, ro}, 32'd1);
    check("drain_valid_second", {31'd0, vo}, 32'd1);
    drive(1'b0, 8'h00, 1'b1, acc, vo, ro);
    check("drain_empty_valid", {31'd0, vo}, 32'd0);
    check("drain_drained", exp_q.size(), 32'd0);

    // 5. Reset while FULL discards held words
    drive(1'b1, 8'h44, 1'b0, acc, vo, ro);
    drive(1'b1, 8'h55, 1'b0, acc, vo, ro);
    reset_i = 1'b1;
    drive(1'b0, 8'h00, 1'b1, acc, vo, ro);
    check("midrst_valid_o", {31'd0, vo}, 32'd0);
    check("midrst_ready_o", {31'd0, ro}, 32'd0);
    reset_i = 1'b0;
    exp_q.delete();
    for (int unsigned i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 1'b1, acc, vo, ro);
      check("midrst_after_valid", {31'd0, vo}, 32'd0);
      check("midrst_after_ready", {31'd0, ro}, 32'd1);
    end

    // 6. Random traffic; upstream holds a word until it is accepted
    hold = 1'b0;
    hd   = '0;
    for (int unsigned c = 0; c < 10000; c++) begin
      v = hold ? 1'b1 : 1'($urandom_range(0, 1));
      d = hold ? hd : 8'($urandom);
      r = 1'($urandom_range(0, 1));
      drive(v, d, r, acc, vo, ro);
      hold = v & ~acc;
      hd   = d;
    end
    repeat (4) drive(1'b0, 8'h00, 1'b1, acc, vo, ro);
    check("random_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
